// File: rtl/axis_fifo_sc.sv
// Single-clock AXI-Stream FIFO with first-word-fall-through output and fill status.
// ADDRESS_WIDTH = 0 collapses the buffer to a single holding register.
module axis_fifo_sc #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDRESS_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_axis_valid,
    output logic                    s_axis_ready,
    input  logic [DATA_WIDTH-1:0]   s_axis_data,
    output logic                    s_axis_full,
    output logic [ADDRESS_WIDTH:0]  s_axis_room,
    output logic                    m_axis_valid,
    input  logic                    m_axis_ready,
    output logic [DATA_WIDTH-1:0]   m_axis_data,
    output logic [ADDRESS_WIDTH:0]  m_axis_level,
    output logic                    m_axis_empty
);

    localparam int AW = ADDRESS_WIDTH;

    generate
        if (AW > 0) begin : g_ram
            localparam logic [AW:0] DEPTH = (AW + 1)'(1) << AW;

            logic [DATA_WIDTH-1:0] mem_q [2**AW];
            logic [AW:0]           wptr_q, wptr_d;
            logic [AW:0]           rptr_q, rptr_d;
            logic [AW:0]           level;
            logic                  full, empty;
            logic                  push, pop;

            // Extra wrap bit lets level span 0..DEPTH without an ambiguous full/empty case.
            always_comb begin
                level = wptr_q - rptr_q;
                full  = (level == DEPTH);
                empty = (level == '0);
                push  = s_axis_valid & ~full;
                pop   = m_axis_ready & ~empty;
                wptr_d = wptr_q;
                rptr_d = rptr_q;
                if (push) wptr_d = wptr_q + (AW + 1)'(1);
                if (pop)  rptr_d = rptr_q + (AW + 1)'(1);
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    wptr_q <= '0;
                    rptr_q <= '0;
                end else begin
                    wptr_q <= wptr_d;
                    rptr_q <= rptr_d;
                end
            end

            always_ff @(posedge clk) begin
                if (!reset && push) mem_q[wptr_q[AW-1:0]] <= s_axis_data;
            end

            assign s_axis_ready = ~full;
            assign s_axis_full  = full;
            assign s_axis_room  = DEPTH - level;
            assign m_axis_valid = ~empty;
            assign m_axis_empty = empty;
            assign m_axis_level = level;
            assign m_axis_data  = mem_q[rptr_q[AW-1:0]];
        end else begin : g_reg
            logic                  flag_q, flag_d;
            logic [DATA_WIDTH-1:0] data_q, data_d;
            logic                  push, pop;

            // Push needs the register empty, so push and pop never coincide here.
            always_comb begin
                push   = s_axis_valid & ~flag_q;
                pop    = m_axis_ready & flag_q;
                flag_d = flag_q;
                data_d = data_q;
                if (push) begin
                    flag_d = 1'b1;
                    data_d = s_axis_data;
                end else if (pop) begin
                    flag_d = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    flag_q <= 1'b0;
                    data_q <= '0;
                end else begin
                    flag_q <= flag_d;
                    data_q <= data_d;
                end
            end

            assign s_axis_ready = ~flag_q;
            assign s_axis_full  = flag_q;
            assign s_axis_room  = ~flag_q;
            assign m_axis_valid = flag_q;
            assign m_axis_empty = ~flag_q;
            assign m_axis_level = flag_q;
            assign m_axis_data  = data_q;
        end
    endgenerate

endmodule

// File: tb/tb_axis_fifo_sc.sv
// Directed bench for axis_fifo_sc: AW=4, AW=2 and AW=0 instances side by side.
module tb_axis_fifo_sc;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // AW=4 instance
    logic        s4_valid, s4_ready, s4_full, m4_valid, m4_ready, m4_empty;
    logic [63:0] s4_data, m4_data;
    logic [4:0]  s4_room, m4_level;
    // AW=2 instance
    logic        s2_valid, s2_ready, s2_full, m2_valid, m2_ready, m2_empty;
    logic [63:0] s2_data, m2_data;
    logic [2:0]  s2_room, m2_level;
    // AW=0 instance
    logic        s0_valid, s0_ready, s0_full, m0_valid, m0_ready, m0_empty;
    logic [63:0] s0_data, m0_data;
    logic [0:0]  s0_room, m0_level;

    axis_fifo_sc #(.DATA_WIDTH(64), .ADDRESS_WIDTH(4)) u_aw4 (
        .clk(clk), .reset(reset),
        .s_axis_valid(s4_valid), .s_axis_ready(s4_ready), .s_axis_data(s4_data),
        .s_axis_full(s4_full), .s_axis_room(s4_room),
        .m_axis_valid(m4_valid), .m_axis_ready(m4_ready), .m_axis_data(m4_data),
        .m_axis_level(m4_level), .m_axis_empty(m4_empty));

    axis_fifo_sc #(.DATA_WIDTH(64), .ADDRESS_WIDTH(2)) u_aw2 (
        .clk(clk), .reset(reset),
        .s_axis_valid(s2_valid), .s_axis_ready(s2_ready), .s_axis_data(s2_data),
        .s_axis_full(s2_full), .s_axis_room(s2_room),
        .m_axis_valid(m2_valid), .m_axis_ready(m2_ready), .m_axis_data(m2_data),
        .m_axis_level(m2_level), .m_axis_empty(m2_empty));

    axis_fifo_sc #(.DATA_WIDTH(64), .ADDRESS_WIDTH(0)) u_aw0 (
        .clk(clk), .reset(reset),
        .s_axis_valid(s0_valid), .s_axis_ready(s0_ready), .s_axis_data(s0_data),
        .s_axis_full(s0_full), .s_axis_room(s0_room),
        .m_axis_valid(m0_valid), .m_axis_ready(m0_ready), .m_axis_data(m0_data),
        .m_axis_level(m0_level), .m_axis_empty(m0_empty));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        s4_valid = 0; s4_data = '0; m4_ready = 0;
        s2_valid = 0; s2_data = '0; m2_ready = 0;
        s0_valid = 0; s0_data = '0; m0_ready = 0;
        step();
        reset = 1'b0;

        // Reset state
        chk("rst4_ready", s4_ready, 1);
        chk("rst4_full",  s4_full,  0);
        chk("rst4_room",  s4_room,  16);
        chk("rst4_valid", m4_valid, 0);
        chk("rst4_empty", m4_empty, 1);
        chk("rst4_level", m4_level, 0);
        chk("rst2_room",  s2_room,  4);
        chk("rst0_ready", s0_ready, 1);
        chk("rst0_room",  s0_room,  1);
        chk("rst0_data",  m0_data,  0);

        // Single word through the AW=4 FIFO
        s4_valid = 1; s4_data = 64'h0123_4567_89AB_CDEF;
        step();
        s4_valid = 0;
        chk("one_valid", m4_valid, 1);
        chk("one_data",  m4_data,  64'h0123_4567_89AB_CDEF);
        chk("one_level", m4_level, 1);
        chk("one_room",  s4_room,  15);
        m4_ready = 1;
        step();
        m4_ready = 0;
        chk("one_pop_valid", m4_valid, 0);
        chk("one_pop_level", m4_level, 0);
        chk("one_pop_room",  s4_room,  16);

        // Fill AW=2, then an ignored extra word, then drain in order
        for (int i = 1; i <= 4; i++) begin
            s2_valid = 1; s2_data = 64'(i);
            step();
        end
        chk("fill_full",  s2_full,  1);
        chk("fill_ready", s2_ready, 0);
        chk("fill_room",  s2_room,  0);
        chk("fill_level", m2_level, 4);
        s2_data = 64'd5;
        m2_ready = 1;
        chk("fill_head", m2_data, 1);
        step();
        // Pop while full must not admit word 5 in that same cycle
        s2_valid = 0;
        m2_ready = 0;
        chk("full_pop_level", m2_level, 3);
        m2_ready = 1;
        for (int i = 2; i <= 4; i++) begin
            chk($sformatf("drain_valid%0d", i), m2_valid, 1);
            chk($sformatf("drain_data%0d", i), m2_data, 64'(i));
            step();
        end
        m2_ready = 0;
        chk("drain_empty", m2_empty, 1);
        chk("drain_room",  s2_room,  4);

        // Streaming 0..9 with one pop per cycle after the first push; pointers wrap
        s2_valid = 1; s2_data = 64'd0;
        step();
        for (int k = 1; k <= 9; k++) begin
            chk($sformatf("strm_level%0d", k), m2_level, 1);
            chk($sformatf("strm_data%0d", k), m2_data, 64'(k - 1));
            s2_data = 64'(k); m2_ready = 1;
            step();
        end
        s2_valid = 0;
        chk("strm_last", m2_data, 9);
        chk("strm_last_level", m2_level, 1);
        step();
        m2_ready = 0;
        chk("strm_empty", m2_empty, 1);

        // AW=0 holding register
        s0_valid = 1; s0_data = 64'hA;
        step();
        s0_data = 64'hB;
        chk("reg_ready", s0_ready, 0);
        chk("reg_valid", m0_valid, 1);
        chk("reg_level", m0_level, 1);
        chk("reg_full",  s0_full,  1);
        chk("reg_data",  m0_data,  64'hA);
        step();
        chk("reg_hold", m0_data, 64'hA);
        m0_ready = 1;
        step();
        m0_ready = 0;
        chk("reg_pop_valid", m0_valid, 0);
        chk("reg_pop_ready", s0_ready, 1);
        step();
        s0_valid = 0;
        chk("reg_next_valid", m0_valid, 1);
        chk("reg_next_data",  m0_data,  64'hB);
        m0_ready = 1;
        step();
        m0_ready = 0;
        chk("reg_final_empty", m0_empty, 1);

        // Reset mid-operation on AW=2, with a push offered during reset
        for (int i = 0; i < 3; i++) begin
            s2_valid = 1; s2_data = 64'h11 * 64'(i + 1);
            step();
        end
        chk("mid_level", m2_level, 3);
        s2_data = 64'h44;
        reset = 1;
        step();
        reset = 0;
        s2_valid = 0;
        chk("mid_rst_level", m2_level, 0);
        chk("mid_rst_empty", m2_empty, 1);
        chk("mid_rst_room",  s2_room,  4);
        chk("mid_rst_valid", m2_valid, 0);
        s2_valid = 1; s2_data = 64'h7;
        step();
        s2_valid = 0;
        chk("mid_first_valid", m2_valid, 1);
        chk("mid_first_data",  m2_data,  64'h7);
        chk("mid_first_level", m2_level, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
